// File: rtl/dpram_be_dual_if.sv
// Avalon-MM style slave bus for one port of dpram_be_dual.
// Optional parity-error lanes are present when DPRAM_BE_DUAL_PARITY_EN is defined.
interface dpram_be_dual_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 7
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              clken;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
`ifdef DPRAM_BE_DUAL_PARITY_EN
    logic [BE_W-1:0]   parerr;
`endif

    modport master (
        output address, chipselect, clken, write, writedata, byteenable,
`ifdef DPRAM_BE_DUAL_PARITY_EN
        input  parerr,
`endif
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, clken, write, writedata, byteenable,
`ifdef DPRAM_BE_DUAL_PARITY_EN
        output parerr,
`endif
        output readdata, readdatavalid
    );
endinterface

// File: rtl/dpram_be_dual.sv
// True dual-port byte-enable RAM with per-port clock enable, 1- or 2-cycle read latency,
// cross-port read-during-write selection (RDW_NEW) and a write/write collision pulse.
// Optional feature macro: DPRAM_BE_DUAL_PARITY_EN (per-byte even parity storage + parerr).
module dpram_be_dual #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned RDW_NEW  = 0
) (
    input  logic            clk_clk,
    input  logic            reset_reset,
    dpram_be_dual_if.slave  s1,
    dpram_be_dual_if.slave  s2,
    output logic            collision
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef DPRAM_BE_DUAL_PARITY_EN
    logic [BE_W-1:0]   r_mem_par [DEPTH];
`endif

    logic [ADDR_W-1:0] w_addr   [2];
    logic [DATA_W-1:0] w_wdata  [2];
    logic [BE_W-1:0]   w_be     [2];
    logic [BE_W-1:0]   w_be_eff [2];
    logic [BE_W-1:0]   w_bmask  [2];
    logic              w_ce     [2];
    logic              w_rd     [2];
    logic              w_wr     [2];
    logic              w_same;
    logic              r_collision;

    // Request decode, s1-wins lane masking and cross-port bypass lane selection.
    always_comb begin
        w_addr[0]  = s1.address;
        w_addr[1]  = s2.address;
        w_wdata[0] = s1.writedata;
        w_wdata[1] = s2.writedata;
        w_be[0]    = s1.byteenable;
        w_be[1]    = s2.byteenable;
        w_ce[0]    = ~reset_reset & s1.clken;
        w_ce[1]    = ~reset_reset & s2.clken;
        w_rd[0]    = w_ce[0] & s1.chipselect & ~s1.write;
        w_rd[1]    = w_ce[1] & s2.chipselect & ~s2.write;
        w_wr[0]    = w_ce[0] & s1.chipselect & s1.write;
        w_wr[1]    = w_ce[1] & s2.chipselect & s2.write;
        w_same     = (w_addr[0] == w_addr[1]);
        w_be_eff[0] = w_be[0];
        w_be_eff[1] = w_be[1] & ~((w_wr[0] && w_same) ? w_be[0] : '0);
        w_bmask[0]  = ((RDW_NEW != 0) && w_rd[0] && w_wr[1] && w_same) ? w_be_eff[1] : '0;
        w_bmask[1]  = ((RDW_NEW != 0) && w_rd[1] && w_wr[0] && w_same) ? w_be_eff[0] : '0;
    end

    // Byte-lane array writes; overlapping s2 lanes were already masked off above.
    always_ff @(posedge clk_clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (w_wr[1] && w_be_eff[1][b]) begin
                r_mem[w_addr[1]][b*8 +: 8] <= w_wdata[1][b*8 +: 8];
`ifdef DPRAM_BE_DUAL_PARITY_EN
                r_mem_par[w_addr[1]][b] <= ^w_wdata[1][b*8 +: 8];
`endif
            end
            if (w_wr[0] && w_be_eff[0][b]) begin
                r_mem[w_addr[0]][b*8 +: 8] <= w_wdata[0][b*8 +: 8];
`ifdef DPRAM_BE_DUAL_PARITY_EN
                r_mem_par[w_addr[0]][b] <= ^w_wdata[0][b*8 +: 8];
`endif
            end
        end
    end

    // Same-address write/write flag, reported one cycle after the writes.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_collision <= 1'b0;
        else             r_collision <= w_wr[0] & w_wr[1] & w_same;
    end

    assign collision = r_collision;

    for (genvar g = 0; g < 2; g++) begin : g_port
        logic [DATA_W-1:0] r_q;
        logic [DATA_W-1:0] r_bdata;
        logic [BE_W-1:0]   r_bmask;
        logic              r_v1;
        logic [DATA_W-1:0] w_m;
        logic [DATA_W-1:0] w_rdata;
        logic              w_rvalid;
        logic [BE_W-1:0]   w_perr;
        logic [BE_W-1:0]   w_parerr;
`ifdef DPRAM_BE_DUAL_PARITY_EN
        logic [BE_W-1:0]   r_pq;
`endif

        // Array read register plus captured bypass lanes; frozen while clken is low.
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                r_q     <= '0;
                r_bdata <= '0;
                r_bmask <= '0;
                r_v1    <= 1'b0;
            end else if (w_ce[g]) begin
                r_v1 <= w_rd[g];
                if (w_rd[g]) begin
                    r_q     <= r_mem[w_addr[g]];
                    r_bmask <= w_bmask[g];
                    r_bdata <= w_wdata[1-g];
                end
            end
        end

`ifdef DPRAM_BE_DUAL_PARITY_EN
        // Stored parity travels alongside the read word.
        always_ff @(posedge clk_clk) begin
            if (reset_reset)            r_pq <= '0;
            else if (w_rd[g])           r_pq <= r_mem_par[w_addr[g]];
        end
`endif

        // Merge bypassed lanes over the array word and flag lanes whose parity fails.
        always_comb begin
            w_m    = r_q;
            w_perr = '0;
            for (int b = 0; b < BE_W; b++) begin
                if (r_bmask[b]) w_m[b*8 +: 8] = r_bdata[b*8 +: 8];
`ifdef DPRAM_BE_DUAL_PARITY_EN
                w_perr[b] = ~r_bmask[b] & ((^r_q[b*8 +: 8]) ^ r_pq[b]);
`endif
            end
        end

        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_d2;
            logic [BE_W-1:0]   r_pe2;
            logic              r_v2;

            // Output register stage, advanced only on enabled cycles.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    r_d2  <= '0;
                    r_pe2 <= '0;
                    r_v2  <= 1'b0;
                end else if (w_ce[g]) begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2  <= w_m;
                        r_pe2 <= w_perr;
                    end
                end
            end

            assign w_rdata  = r_d2;
            assign w_rvalid = r_v2;
            assign w_parerr = r_v2 ? r_pe2 : '0;
        end else begin : g_lat1
            assign w_rdata  = w_m;
            assign w_rvalid = r_v1;
            assign w_parerr = r_v1 ? w_perr : '0;
        end
    end

    assign s1.readdata      = g_port[0].w_rdata;
    assign s1.readdatavalid = g_port[0].w_rvalid;
    assign s2.readdata      = g_port[1].w_rdata;
    assign s2.readdatavalid = g_port[1].w_rvalid;
`ifdef DPRAM_BE_DUAL_PARITY_EN
    assign s1.parerr        = g_port[0].w_parerr;
    assign s2.parerr        = g_port[1].w_parerr;
`endif

endmodule

// File: tb/tb_dpram_be_dual.sv
// Bench for dpram_be_dual: two instances in lockstep (A: READ_LAT=1/RDW_NEW=0,
// B: READ_LAT=2/RDW_NEW=1) against a word-array + pending-read-queue reference model.
module tb_dpram_be_dual;
    logic        clk = 1'b0;
    logic        rst;
    logic        cs [2];
    logic        ce [2];
    logic        wr [2];
    logic [6:0]  addr [2];
    logic [63:0] wd [2];
    logic [7:0]  be [2];
    logic        col_a, col_b;
    logic [7:0]  pe_act [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dpram_be_dual_if #(.DATA_W(64), .ADDR_W(7)) a1 ();
    dpram_be_dual_if #(.DATA_W(64), .ADDR_W(7)) a2 ();
    dpram_be_dual_if #(.DATA_W(64), .ADDR_W(7)) b1 ();
    dpram_be_dual_if #(.DATA_W(64), .ADDR_W(7)) b2 ();

    assign a1.address = addr[0]; assign b1.address = addr[0];
    assign a2.address = addr[1]; assign b2.address = addr[1];
    assign a1.chipselect = cs[0]; assign b1.chipselect = cs[0];
    assign a2.chipselect = cs[1]; assign b2.chipselect = cs[1];
    assign a1.clken = ce[0]; assign b1.clken = ce[0];
    assign a2.clken = ce[1]; assign b2.clken = ce[1];
    assign a1.write = wr[0]; assign b1.write = wr[0];
    assign a2.write = wr[1]; assign b2.write = wr[1];
    assign a1.writedata = wd[0]; assign b1.writedata = wd[0];
    assign a2.writedata = wd[1]; assign b2.writedata = wd[1];
    assign a1.byteenable = be[0]; assign b1.byteenable = be[0];
    assign a2.byteenable = be[1]; assign b2.byteenable = be[1];

`ifdef DPRAM_BE_DUAL_PARITY_EN
    assign pe_act[0] = a1.parerr; assign pe_act[1] = a2.parerr;
    assign pe_act[2] = b1.parerr; assign pe_act[3] = b2.parerr;
`else
    assign pe_act[0] = 8'h00; assign pe_act[1] = 8'h00;
    assign pe_act[2] = 8'h00; assign pe_act[3] = 8'h00;
`endif

    dpram_be_dual #(.DATA_W(64), .ADDR_W(7), .READ_LAT(1), .RDW_NEW(0)) dut_a (
        .clk_clk(clk), .reset_reset(rst), .s1(a1), .s2(a2), .collision(col_a));
    dpram_be_dual #(.DATA_W(64), .ADDR_W(7), .READ_LAT(2), .RDW_NEW(1)) dut_b (
        .clk_clk(clk), .reset_reset(rst), .s1(b1), .s2(b2), .collision(col_b));

    // Reference model: word array, per-lane corrupted-parity flags, pending reads per port.
    typedef struct { int cnt; logic [63:0] d; logic [7:0] pe; } pend_t;
    pend_t       pq [4][$];
    logic [63:0] mem_m [128];
    logic [7:0]  pflag [128];
    logic        ev [4];
    logic [63:0] ed [4];
    logic [7:0]  epe [4];
    logic        ecol [2];
    int          lat_of [2] = '{1, 2};

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step_model();
        bit          wrp [2];
        bit          same;
        int          o;
        int          j;
        logic [63:0] rdat;
        logic [7:0]  msk;
        same = (addr[0] == addr[1]);
        for (int p = 0; p < 2; p++) wrp[p] = !rst && cs[p] && ce[p] && wr[p];
        for (int k = 0; k < 2; k++) begin
            ecol[k] = !rst && wrp[0] && wrp[1] && same;
            for (int p = 0; p < 2; p++) begin
                j = k * 2 + p;
                o = 1 - p;
                if (rst) begin
                    pq[j].delete();
                    ev[j] = 1'b0; ed[j] = '0; epe[j] = '0;
                end else if (ce[p]) begin
                    if (cs[p] && !wr[p]) begin
                        msk  = (k == 1 && wrp[o] && same) ? be[o] : 8'h00;
                        rdat = mem_m[addr[p]];
                        for (int b = 0; b < 8; b++)
                            if (msk[b]) rdat[b*8 +: 8] = wd[o][b*8 +: 8];
                        pq[j].push_back('{cnt: lat_of[k], d: rdat, pe: pflag[addr[p]] & ~msk});
                    end
                    for (int i = 0; i < pq[j].size(); i++) pq[j][i].cnt = pq[j][i].cnt - 1;
                    ev[j] = 1'b0; epe[j] = '0;
                    if (pq[j].size() > 0 && pq[j][0].cnt == 0) begin
                        ev[j] = 1'b1; ed[j] = pq[j][0].d; epe[j] = pq[j][0].pe;
                        void'(pq[j].pop_front());
                    end
                end
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (wrp[1] && be[1][b]) begin
                mem_m[addr[1]][b*8 +: 8] = wd[1][b*8 +: 8]; pflag[addr[1]][b] = 1'b0;
            end
            if (wrp[0] && be[0][b]) begin
                mem_m[addr[0]][b*8 +: 8] = wd[0][b*8 +: 8]; pflag[addr[0]][b] = 1'b0;
            end
        end
    endtask

    task automatic cmp_port(string tag, int j, logic v, logic [63:0] d, logic [7:0] pe);
        check_eq({tag, ".valid"}, 64'(v), 64'(ev[j]));
        check_eq({tag, ".data"}, d, ed[j]);
`ifdef DPRAM_BE_DUAL_PARITY_EN
        check_eq({tag, ".parerr"}, 64'(pe), 64'(epe[j]));
`else
        if (pe != 8'h00) check_eq({tag, ".parerr"}, 64'(pe), 64'h0);
`endif
    endtask

    task automatic compare_all();
        cmp_port("A.s1", 0, a1.readdatavalid, a1.readdata, pe_act[0]);
        cmp_port("A.s2", 1, a2.readdatavalid, a2.readdata, pe_act[1]);
        cmp_port("B.s1", 2, b1.readdatavalid, b1.readdata, pe_act[2]);
        cmp_port("B.s2", 3, b2.readdatavalid, b2.readdata, pe_act[3]);
        check_eq("A.collision", 64'(col_a), 64'(ecol[0]));
        check_eq("B.collision", 64'(col_b), 64'(ecol[1]));
    endtask

    task automatic tick();
        step_model();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0; ce[p] = 1'b1; wr[p] = 1'b0;
            addr[p] = '0; wd[p] = '0; be[p] = '0;
        end
    endtask

    task automatic drv(int p, bit w, int a, logic [63:0] d, logic [7:0] b);
        cs[p] = 1'b1; wr[p] = w; addr[p] = 7'(a); wd[p] = d; be[p] = b;
    endtask

`ifdef DPRAM_BE_DUAL_PARITY_EN
    task automatic corrupt(int a, int l);
        dut_a.r_mem_par[a][l] <= ~dut_a.r_mem_par[a][l];
        dut_b.r_mem_par[a][l] <= ~dut_b.r_mem_par[a][l];
        pflag[a][l] = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) begin mem_m[i] = '0; pflag[i] = '0; end
        rst = 1'b1;
        set_idle();
        tick(); tick();
        rst = 1'b0;
        check_eq("reset_a_s1_data", a1.readdata, 64'h0);
        check_eq("reset_b_s2_valid", 64'(b2.readdatavalid), 64'h0);

        // Prefill the working address range so both DUTs and the model agree.
        for (int a = 0; a < 16; a++) begin
            set_idle(); drv(0, 1'b1, a, {$urandom(), $urandom()}, 8'hFF); tick();
        end

        // Full write then cross-port read.
        set_idle(); drv(0, 1'b1, 5, 64'h0123456789ABCDEF, 8'hFF); tick();
        set_idle(); drv(1, 1'b0, 5, '0, '0); tick();
        check_eq("t1_a_valid", 64'(a2.readdatavalid), 64'h1);
        check_eq("t1_a_data", a2.readdata, 64'h0123456789ABCDEF);
        set_idle(); tick();
        check_eq("t1_b_valid", 64'(b2.readdatavalid), 64'h1);
        check_eq("t1_b_data", b2.readdata, 64'h0123456789ABCDEF);

        // Partial byte-enable write.
        set_idle(); drv(0, 1'b1, 5, 64'hFFFFFFFFFFFFFFFF, 8'h0F); tick();
        set_idle(); drv(0, 1'b0, 5, '0, '0); tick();
        check_eq("t2_a_data", a1.readdata, 64'h01234567FFFFFFFF);
        set_idle(); tick();
        check_eq("t2_b_data", b1.readdata, 64'h01234567FFFFFFFF);

        // Write/write collision: s1 wins.
        set_idle(); drv(0, 1'b1, 9, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        drv(1, 1'b1, 9, 64'h5555555555555555, 8'hFF); tick();
        check_eq("t3_collision", 64'(col_a), 64'h1);
        set_idle(); drv(1, 1'b0, 9, '0, '0); tick();
        check_eq("t3_collision_drop", 64'(col_a), 64'h0);
        check_eq("t3_a_data", a2.readdata, 64'hAAAAAAAAAAAAAAAA);
        set_idle(); tick();
        check_eq("t3_b_data", b2.readdata, 64'hAAAAAAAAAAAAAAAA);

        // Cross-port read-during-write: old data on A, new data on B.
        set_idle(); drv(0, 1'b1, 3, 64'h11, 8'hFF); tick();
        set_idle(); drv(1, 1'b0, 3, '0, '0); drv(0, 1'b1, 3, 64'h22, 8'hFF); tick();
        check_eq("t4_a_old", a2.readdata, 64'h11);
        set_idle(); tick();
        check_eq("t4_b_new", b2.readdata, 64'h22);

        // Clock-enable stall on a latency-2 read.
        set_idle(); drv(0, 1'b0, 5, '0, '0); tick();
        set_idle(); ce[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t5_b_held", 64'(b1.readdatavalid), 64'h0);
        end
        set_idle(); tick();
        check_eq("t5_b_valid", 64'(b1.readdatavalid), 64'h1);
        check_eq("t5_b_data", b1.readdata, 64'h01234567FFFFFFFF);

        // Reset while a read is in flight.
        set_idle(); drv(0, 1'b0, 5, '0, '0); tick();
        set_idle(); rst = 1'b1; tick();
        rst = 1'b0; tick(); tick();
        check_eq("t5r_b_valid", 64'(b1.readdatavalid), 64'h0);
        check_eq("t5r_b_data", b1.readdata, 64'h0);

`ifdef DPRAM_BE_DUAL_PARITY_EN
        // Parity corruption detected on the affected lane only.
        set_idle(); drv(0, 1'b1, 12, 64'h0F1E2D3C4B5A6978, 8'hFF); tick();
        corrupt(12, 2);
        set_idle(); drv(0, 1'b0, 12, '0, '0); tick();
        check_eq("t6_a_parerr", 64'(pe_act[0]), 64'h04);
        set_idle(); tick();
        check_eq("t6_b_parerr", 64'(pe_act[2]), 64'h04);
        set_idle(); drv(0, 1'b1, 12, 64'h0F1E2D3C4B5A6978, 8'hFF); tick();
`endif

        // Randomized traffic over a small address window to provoke conflicts.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 3) != 0);
                ce[p]   = ($urandom_range(0, 7) != 0);
                wr[p]   = 1'($urandom_range(0, 1));
                addr[p] = 7'($urandom_range(0, 15));
                wd[p]   = {$urandom(), $urandom()};
                be[p]   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            end
            tick();
        end

        set_idle(); rst = 1'b0; tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
